// File: rtl/frame_sequencer_pkg.sv
// Shared LED-path types: sequencer state encoding, colour width and the RGB word
// used by the frame sequencer, pixel driver and pattern generators.
package led_pkg;

  localparam int COLOR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_SCALE   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_LATCH   = 3'd4
  } fseq_state_t;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } rgb_t;

  // (c * (bri + 1)) >> 8: bri = 255 passes c through, bri = 0 yields 0.
  function automatic logic [COLOR_W-1:0] scale_chan(input logic [COLOR_W-1:0] c,
                                                    input logic [COLOR_W-1:0] bri);
    logic [COLOR_W:0]     mult;
    logic [2*COLOR_W-1:0] prod;
    mult = {1'b0, bri} + (COLOR_W+1)'(1);
    prod = (2*COLOR_W)'(c) * (2*COLOR_W)'(mult);
    return COLOR_W'(prod >> COLOR_W);
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Source-request and driver-word handshakes between the frame sequencer,
// the pattern generator and the serial pixel driver.
interface frame_sequencer_if import led_pkg::*; #(parameter int IDX_W = 10) ();

  logic               src_valid;
  logic [IDX_W-1:0]   src_index;
  logic               src_ready;
  logic [COLOR_W-1:0] src_red;
  logic [COLOR_W-1:0] src_green;
  logic [COLOR_W-1:0] src_blue;

  logic               drv_valid;
  logic               drv_ready;
  logic               drv_reset;
  logic [COLOR_W-1:0] drv_red;
  logic [COLOR_W-1:0] drv_green;
  logic [COLOR_W-1:0] drv_blue;

  modport master (
    output src_valid, src_index,
    input  src_ready, src_red, src_green, src_blue,
    output drv_valid, drv_reset, drv_red, drv_green, drv_blue,
    input  drv_ready
  );

  modport slave (
    input  src_valid, src_index,
    output src_ready, src_red, src_green, src_blue,
    input  drv_valid, drv_reset, drv_red, drv_green, drv_blue,
    output drv_ready
  );

endinterface

// File: rtl/frame_sequencer_rgb_scaler.sv
// Registered three-channel brightness scaler; loads a new result only when
// asked so the output word stays stable while the driver stalls.
module rgb_scaler import led_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [COLOR_W-1:0] bri,
  input  rgb_t               pix,
  output rgb_t               scaled
);

  rgb_t scaled_d;

  always_comb begin
    scaled_d       = '0;
    scaled_d.red   = scale_chan(pix.red,   bri);
    scaled_d.green = scale_chan(pix.green, bri);
    scaled_d.blue  = scale_chan(pix.blue,  bri);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scaled <= '0;
    end else if (load) begin
      scaled <= scaled_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Walks the pixel index across the panel, fetches and scales each pixel, hands it
// to the pixel driver and closes every frame with a latch word; scrolls per FRAME_DIV.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | stopped, all outputs 0, waits for enable
// ST_FETCH   | requesting pixel (pix_idx + scroll_offset) mod LED from source
// ST_SCALE   | captured colour goes through the brightness scaler
// ST_PRESENT | scaled word offered to the driver until accepted
// ST_LATCH   | end-of-frame latch word (drv_reset, colours 0) offered to driver
module frame_sequencer import led_pkg::*; #(
  parameter int LED       = 256,
  parameter int FRAME_DIV = 1,
  parameter int IDX_W     = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [COLOR_W-1:0] brightness,
  frame_sequencer_if.master  bus,
  output logic               frame_done,
  output logic [IDX_W-1:0]   scroll_offset
);

  localparam int                FC_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LED - 1);
  localparam logic [IDX_W:0]    LED_EXT  = (IDX_W+1)'(LED);
  localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(FRAME_DIV - 1);

  fseq_state_t        state_q;
  fseq_state_t        state_d;
  logic [IDX_W-1:0]   pix_idx_q;
  logic [FC_W-1:0]    frame_cnt_q;
  logic [COLOR_W-1:0] bri_q;
  rgb_t               src_q;
  rgb_t               scaled_q;
  logic [IDX_W:0]     idx_sum;
  logic [IDX_W-1:0]   idx_wrap;
  logic               start_frame;
  logic               fetch_xfer;
  logic               px_xfer;
  logic               latch_xfer;
  logic               scale_load;
  logic               in_present;

  // Both operands are below LED, so one conditional subtract is a full modulo.
  always_comb begin
    idx_sum = {1'b0, pix_idx_q} + {1'b0, scroll_offset};
    if (idx_sum >= LED_EXT) begin
      idx_wrap = IDX_W'(idx_sum - LED_EXT);
    end else begin
      idx_wrap = idx_sum[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    fetch_xfer  = 1'b0;
    px_xfer     = 1'b0;
    latch_xfer  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          start_frame = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.src_ready) begin
          fetch_xfer = 1'b1;
          state_d    = ST_SCALE;
        end
      end
      ST_SCALE: begin
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.drv_ready) begin
          px_xfer = 1'b1;
          state_d = (pix_idx_q == LAST_IDX) ? ST_LATCH : ST_FETCH;
        end
      end
      ST_LATCH: begin
        if (bus.drv_ready) begin
          latch_xfer = 1'b1;
          if (enable) begin
            start_frame = 1'b1;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_idx_q     <= '0;
      bri_q         <= '0;
      src_q         <= '0;
      frame_cnt_q   <= '0;
      scroll_offset <= '0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= latch_xfer;
      if (start_frame) begin
        pix_idx_q <= '0;
        bri_q     <= brightness;
      end else if (px_xfer && (pix_idx_q != LAST_IDX)) begin
        pix_idx_q <= pix_idx_q + IDX_W'(1);
      end
      if (fetch_xfer) begin
        src_q <= {bus.src_red, bus.src_green, bus.src_blue};
      end
      // Scroll moves backwards so the pattern appears to advance along the strip.
      if (latch_xfer) begin
        if (frame_cnt_q == FC_LAST) begin
          frame_cnt_q   <= '0;
          scroll_offset <= (scroll_offset == '0) ? LAST_IDX : scroll_offset - IDX_W'(1);
        end else begin
          frame_cnt_q <= frame_cnt_q + FC_W'(1);
        end
      end
    end
  end

  assign scale_load = (state_q == ST_SCALE);

  rgb_scaler u_scaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (scale_load),
    .bri    (bri_q),
    .pix    (src_q),
    .scaled (scaled_q)
  );

  assign in_present    = (state_q == ST_PRESENT);
  assign bus.src_valid = (state_q == ST_FETCH);
  assign bus.src_index = (state_q == ST_FETCH) ? idx_wrap : '0;
  assign bus.drv_valid = in_present || (state_q == ST_LATCH);
  assign bus.drv_reset = (state_q == ST_LATCH);
  assign bus.drv_red   = in_present ? scaled_q.red   : '0;
  assign bus.drv_green = in_present ? scaled_q.green : '0;
  assign bus.drv_blue  = in_present ? scaled_q.blue  : '0;

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(bus.src_valid && bus.drv_valid));

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on a 4-pixel panel scrolling every 2 frames.
module tb_frame_sequencer;
  import led_pkg::*;

  localparam int LED       = 4;
  localparam int FRAME_DIV = 2;
  localparam int IDX_W     = 10;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [7:0]       brightness;
  logic             frame_done;
  logic [IDX_W-1:0] scroll_offset;

  frame_sequencer_if #(.IDX_W(IDX_W)) bus ();

  frame_sequencer #(.LED(LED), .FRAME_DIV(FRAME_DIV), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .brightness    (brightness),
    .bus           (bus.master),
    .frame_done    (frame_done),
    .scroll_offset (scroll_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] bri, r, g, b;
    logic [7:0] er, eg, eb;
    int         off;
    int         stall_pix;
    int         drop_pix;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_src_valid"}, int'(bus.src_valid), 0);
    chk({tag, "_src_index"}, int'(bus.src_index), 0);
    chk({tag, "_drv_valid"}, int'(bus.drv_valid), 0);
    chk({tag, "_drv_reset"}, int'(bus.drv_reset), 0);
    chk({tag, "_drv_rgb"}, int'({bus.drv_red, bus.drv_green, bus.drv_blue}), 0);
  endtask

  // Called at a negedge at or before the first FETCH of the frame; returns at the
  // negedge where frame_done should be high.
  task automatic do_frame(input vec_t v, input logic [7:0] next_bri);
    int pix       = 0;
    int stall_cnt = 0;
    bit seen_latch = 0;
    bit done_ok    = 0;
    bus.src_red   = v.r;
    bus.src_green = v.g;
    bus.src_blue  = v.b;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (seen_latch) begin
        chk("frame_done_pulse", int'(frame_done), 1);
        done_ok = 1;
        break;
      end
      if (cyc == 0) chk("scroll_offset", int'(scroll_offset), v.off);
      else          chk("frame_done_low", int'(frame_done), 0);
      if (bus.src_valid) begin
        chk("src_drv_overlap", int'(bus.drv_valid), 0);
        chk("src_index", int'(bus.src_index), (pix + v.off) % LED);
        if (pix == 1) brightness = 8'h5A;
        if (pix == v.drop_pix) enable = 1'b0;
      end
      if (bus.drv_valid && !bus.drv_reset) begin
        chk("drv_rgb", int'({bus.drv_red, bus.drv_green, bus.drv_blue}),
            int'({v.er, v.eg, v.eb}));
        if (pix == v.stall_pix && stall_cnt < 5) begin
          bus.drv_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.drv_ready = 1'b1;
          pix++;
        end
      end else if (bus.drv_reset) begin
        chk("latch_valid", int'(bus.drv_valid), 1);
        chk("latch_rgb", int'({bus.drv_red, bus.drv_green, bus.drv_blue}), 0);
        chk("pix_count", pix, LED);
        bus.drv_ready = 1'b1;
        brightness    = next_bri;
        seen_latch    = 1;
      end
      @(negedge clk);
    end
    if (!done_ok) chk("frame_timeout", 0, 1);
    if (v.stall_pix < LED) chk("stall_cycles", stall_cnt, 5);
  endtask

  initial begin
    tbl[0] = '{bri: 8'hFF, r: 8'h12, g: 8'h34, b: 8'h56, er: 8'h12, eg: 8'h34, eb: 8'h56,
               off: 0, stall_pix: 99, drop_pix: 99};
    tbl[1] = '{bri: 8'd127, r: 8'hFF, g: 8'h80, b: 8'h01, er: 8'h7F, eg: 8'h40, eb: 8'h00,
               off: 0, stall_pix: 2, drop_pix: 99};
    tbl[2] = '{bri: 8'd0, r: 8'hC8, g: 8'h64, b: 8'hFF, er: 8'h00, eg: 8'h00, eb: 8'h00,
               off: 3, stall_pix: 99, drop_pix: 99};
    tbl[3] = '{bri: 8'd63, r: 8'hC8, g: 8'h64, b: 8'hFF, er: 8'h32, eg: 8'h19, eb: 8'h3F,
               off: 3, stall_pix: 99, drop_pix: 1};
    tbl[4] = '{bri: 8'hFF, r: 8'h11, g: 8'h22, b: 8'h33, er: 8'h11, eg: 8'h22, eb: 8'h33,
               off: 0, stall_pix: 99, drop_pix: 0};

    rst_n         = 1'b0;
    enable        = 1'b0;
    brightness    = tbl[0].bri;
    bus.src_ready = 1'b1;
    bus.drv_ready = 1'b1;
    bus.src_red   = '0;
    bus.src_green = '0;
    bus.src_blue  = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_scroll", int'(scroll_offset), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_outputs_zero("idle");

    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_frame(tbl[i], (i < 3) ? tbl[i+1].bri : 8'hFF);
    end

    chk_outputs_zero("after_drop");
    @(negedge clk);
    chk_outputs_zero("idle_stopped");
    chk("idle_frame_done", int'(frame_done), 0);
    chk("offset_after_4", int'(scroll_offset), 2);

    // Restart with offset 2, then reset while a pixel is being presented.
    brightness = 8'hFF;
    enable     = 1'b1;
    begin
      bit first_seen = 0;
      bit hit        = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
        @(negedge clk);
        if (bus.src_valid && !first_seen) begin
          chk("restart_first_index", int'(bus.src_index), 2);
          first_seen = 1;
        end
        if (bus.drv_valid) begin
          hit = 1;
          break;
        end
      end
      chk("present_reached", int'(hit), 1);
    end
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    chk("async_reset_scroll", int'(scroll_offset), 0);
    chk("async_reset_done", int'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(tbl[4], 8'hFF);
    @(negedge clk);
    chk_outputs_zero("final_idle");
    chk("final_offset", int'(scroll_offset), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
